// File: rtl/ifu_addarb_pkg.sv
// Shared types for the IFU adder arbiter.
// Build option IFU_ADDARB_OVF_EN adds a signed-overflow flag to the S2 record.
package ifu_addarb_pkg;

  localparam int DATA_W = 16;
  localparam int SUM_W  = 17;
  localparam int ID_W   = 2;  // wide enough for NREQ up to 4

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic [ID_W-1:0]   id;
  } s1_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [ID_W-1:0]  id;
`ifdef IFU_ADDARB_OVF_EN
    logic             ovf;
`endif
  } s2_t;

  typedef enum logic {
    PRIO_RR    = 1'b0,
    PRIO_FIXED = 1'b1
  } prio_mode_e;

endpackage

// File: rtl/ifu_rr_arb.sv
// NREQ-way grant: round-robin from rr_ptr_q, or fixed priority (index 0 highest).
// Grant is combinational from req; the pointer only moves when advance reports a transfer.
module ifu_rr_arb
  import ifu_addarb_pkg::*;
#(
  parameter int  NREQ      = 3,
  parameter int  PRIO_MODE = 0,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam bit FIXED = (PRIO_MODE == int'(PRIO_FIXED));

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] start;
  logic [IDW-1:0] gidx;

  always_comb begin : grant_search
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    start = FIXED ? '0 : rr_ptr_q;
    grant = '0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(start) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && !FIXED) begin
      rr_ptr_d = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/sum16bit.sv
// IFU 16-bit Kogge-Stone prefix adder, purely combinational.
// kIn = {generate, propagate} of the carry-in slot; with nothing below it, carry enters if either is set.
module sum16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  kIn,
  output logic [16:0] sum
);

  function automatic logic [16:0] prefix_add(input logic [15:0] x, input logic [15:0] y,
                                             input logic c0);
    logic [15:0] g, p, gg, pp;
    g  = x & y;
    p  = x ^ y;
    gg = g;
    pp = p;
    gg[0] = g[0] | (p[0] & c0);
    // Descending index keeps gg[i-d]/pp[i-d] at the previous level's value.
    for (int d = 1; d < 16; d = d * 2) begin
      for (int i = 15; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    return {gg[15], p ^ {gg[14:0], c0}};
  endfunction

  assign sum = prefix_add(a, b, kIn[1] | kIn[0]);

endmodule

// File: rtl/ifu_adder_arbiter.sv
// Shares one sum16bit among NREQ requesters: arbitrate -> S1 operands -> adder -> S2 {sum,id}; 2-cycle latency.
// Full valid/ready backpressure, at most 2 in flight; IFU_ADDARB_OVF_EN adds the rsp_ovf output.
module ifu_adder_arbiter
  import ifu_addarb_pkg::*;
#(
  parameter int  NREQ      = 3,
  parameter int  PRIO_MODE = 0,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [SUM_W-1:0]       rsp_sum,
  output logic [IDW-1:0]         rsp_id,
`ifdef IFU_ADDARB_OVF_EN
  output logic                   rsp_ovf,
`endif
  output logic                   busy
);

  logic [NREQ-1:0]  grant;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s1_load, s2_load, xfer;
  s1_t              s1_q, s1_d, s1_sel;
  s2_t              s2_q, s2_d;
  logic [SUM_W-1:0] add_sum;

  assign s2_load   = s1_valid_q & (~s2_valid_q | rsp_ready);
  assign s1_load   = ~s1_valid_q | s2_load;
  assign req_ready = grant & {NREQ{s1_load}};
  // grant only ever selects a valid requester, so any ready bit is a transfer
  assign xfer      = |req_ready;

  ifu_rr_arb #(
    .NREQ      (NREQ),
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (xfer),
    .grant   (grant)
  );

  always_comb begin
    s1_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        s1_sel.a   = req_a[DATA_W*i +: DATA_W];
        s1_sel.b   = req_b[DATA_W*i +: DATA_W];
        s1_sel.cin = req_cin[i];
        s1_sel.id  = ID_W'(i);
      end
    end
  end

  sum16bit u_add (
    .a   (s1_q.a),
    .b   (s1_q.b),
    .kIn ({s1_q.cin, s1_q.cin}),
    .sum (add_sum)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (xfer) begin
      s1_valid_d = 1'b1;
      s1_d       = s1_sel;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_d.sum   = add_sum;
      s2_d.id    = s1_q.id;
`ifdef IFU_ADDARB_OVF_EN
      s2_d.ovf   = (s1_q.a[DATA_W-1] == s1_q.b[DATA_W-1]) &
                   (add_sum[DATA_W-1] != s1_q.a[DATA_W-1]);
`endif
    end else if (rsp_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_sum   = s2_q.sum;
  assign rsp_id    = s2_q.id[IDW-1:0];
  assign busy      = s1_valid_q | s2_valid_q;
`ifdef IFU_ADDARB_OVF_EN
  assign rsp_ovf   = s2_q.ovf;
`endif

endmodule
